// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  // Sequencer states; encoding 2'd3 is unused and recovers to StHold.
  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } state_e;

  // Register offsets (only paddr[7:0] is decoded).
  localparam logic [7:0] ADDR_DLY    = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_SEQCNT = 8'h08;

  // Domain index width; covers up to 8 domains.
  localparam int unsigned IDX_W = 3;

  // Completed-sequence counter width.
  localparam int unsigned SEQCNT_W = 16;

  // Saturating increment for the sequence counter.
  function automatic logic [SEQCNT_W-1:0] sat_inc(input logic [SEQCNT_W-1:0] v);
    if (v == {SEQCNT_W{1'b1}}) begin
      return v;
    end
    return v + SEQCNT_W'(1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// APB slave bus bundle for the reset sequencer.
interface rst_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic pclk,
  input  logic presetn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous input, then retime once more to settle metastability.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases N_DOM reset domains in ascending order with a
// programmable gap, and exposes DLY/STATUS/SEQCNT over APB.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_DOM      = 4,
  parameter int unsigned DLY_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             pclk,
  input  logic             presetn,
  rst_seq_if.slave         apb,
  input  logic             sys_rst_n_i,
  output logic [N_DOM-1:0] dom_rst_n
);

  localparam logic [DLY_WIDTH-1:0] DlyReset = DLY_WIDTH'(16);
  localparam logic [IDX_W-1:0]     IdxLast  = IDX_W'(N_DOM - 1);

  // ---------------------------------------------------------------------------
  // Request synchronizer
  // ---------------------------------------------------------------------------
  logic rst_req_n;

  sync_2ff u_sync (
    .pclk    (pclk),
    .presetn (presetn),
    .d       (sys_rst_n_i),
    .q       (rst_req_n)
  );

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic       wr_strobe;
  logic       rd_strobe;
  logic [7:0] reg_addr;

  assign wr_strobe = apb.psel & apb.penable & apb.pwrite;
  // Reads are captured in the setup phase so prdata is ready for the access phase.
  assign rd_strobe = apb.psel & ~apb.penable & ~apb.pwrite;
  assign reg_addr  = apb.paddr[7:0];

  // Address bits above the decoded byte and data bits above DLY are ignored.
  logic unused_bits;
  assign unused_bits = ^{apb.paddr[ADDR_WIDTH-1:8], apb.pwdata[DATA_WIDTH-1:DLY_WIDTH]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DLY_WIDTH-1:0]  dly_q;
  logic [DLY_WIDTH-1:0]  cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [N_DOM-1:0]      dom_rst_n_q;
  logic [SEQCNT_W-1:0]   seqcnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  state_e                state_q;

  // DLY register; a write only affects the next counter reload.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      dly_q <= DlyReset;
    end else if (wr_strobe && (reg_addr == ADDR_DLY)) begin
      dly_q <= apb.pwdata[DLY_WIDTH-1:0];
    end
  end

  // Sequencer FSM; all domain resets are registered here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rst_n_q <= '0;
      seqcnt_q    <= '0;
    end else if (!rst_req_n) begin
      // A reset request overrides every state.
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rst_n_q <= '0;
    end else begin
      case (state_q)
        StHold: begin
          dom_rst_n_q <= '0;
          cnt_q       <= dly_q;
          idx_q       <= '0;
          state_q     <= StRelease;
        end
        StRelease: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DLY_WIDTH'(1);
          end else begin
            dom_rst_n_q <= dom_rst_n_q | (N_DOM'(1) << idx_q);
            if (idx_q == IdxLast) begin
              state_q  <= StRun;
              seqcnt_q <= sat_inc(seqcnt_q);
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              cnt_q <= dly_q;
            end
          end
        end
        StRun: begin
          dom_rst_n_q <= '1;
        end
        default: begin
          state_q     <= StHold;
          cnt_q       <= '0;
          idx_q       <= '0;
          dom_rst_n_q <= '0;
        end
      endcase
    end
  end

  assign dom_rst_n = dom_rst_n_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  // Read mux; unmapped offsets and unused bits read as zero.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      ADDR_DLY: begin
        rdata_d[DLY_WIDTH-1:0] = dly_q;
      end
      ADDR_STATUS: begin
        rdata_d[1:0]       = state_q;
        rdata_d[6:4]       = idx_q;
        rdata_d[8 +: N_DOM] = dom_rst_n_q;
      end
      ADDR_SEQCNT: begin
        rdata_d[SEQCNT_W-1:0] = seqcnt_q;
      end
      default: begin
        rdata_d = '0;
      end
    endcase
  end

  // Registered read data, updated only by a read strobe.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else if (rd_strobe) begin
      prdata_q <= rdata_d;
    end
  end

  assign apb.prdata = prdata_q;

endmodule
